// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and default widths for the instruction fetch unit.
package cpu_pkg;

  localparam int unsigned IF_ADDR_W = 32;
  localparam int unsigned IF_DATA_W = 32;
  localparam logic [IF_DATA_W-1:0] IF_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register plus a one-entry skid buffer that catches a word
// returned while decode is stalled on an occupied IF/ID.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic              skid_load,
  input  logic              skid_pop,
  input  logic              bubble,
  input  logic [DATA_W-1:0] word,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  logic [DATA_W-1:0] skid_inst_r;
  logic [ADDR_W-1:0] skid_pc_r;

  // IF/ID register: clear beats capture beats skid drain beats bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= NOP_INST;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else if (clear) begin
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (capture) begin
      inst       <= word;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
    end else if (skid_pop) begin
      inst       <= skid_inst_r;
      inst_pc    <= skid_pc_r;
      inst_valid <= 1'b1;
    end else if (bubble) begin
      inst_valid <= 1'b0;
    end
  end

  // Skid entry: only meaningful while the fetch FSM sits in S_HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_inst_r <= NOP_INST;
      skid_pc_r   <= '0;
    end else if (clear) begin
      skid_inst_r <= NOP_INST;
      skid_pc_r   <= '0;
    end else if (skid_load) begin
      skid_inst_r <= word;
      skid_pc_r   <= pc;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: drives memory req/ack from the PC, fills IF/ID and
// returns stall_o to the PC register; flushes squash wrong-path fetches.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              id_stall_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);

  fetch_state_e      state_r;
  fetch_state_e      next_state_s;
  logic [ADDR_W-1:0] addr_q_r;
  logic [ADDR_W-1:0] addr_s;
  logic              stall_s;
  logic              req_s;
  logic              capture_s;
  logic              skid_load_s;
  logic              skid_pop_s;
  logic              bubble_s;
  logic              clear_s;

  // Fetch state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Address of the outstanding request, replayed while draining after a flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q_r <= '0;
    end else if (state_r == S_REQ) begin
      addr_q_r <= pc_i;
    end else begin
      addr_q_r <= addr_q_r;
    end
  end

  // Next state, handshake and IF/ID controls; priority flush > id_stall > ack.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b1;
    req_s        = 1'b0;
    addr_s       = addr_q_r;
    capture_s    = 1'b0;
    skid_load_s  = 1'b0;
    skid_pop_s   = 1'b0;
    bubble_s     = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        next_state_s = S_REQ;
      end
      S_REQ: begin
        req_s  = 1'b1;
        addr_s = pc_i;
        if (flush_i) begin
          clear_s      = 1'b1;
          stall_s      = 1'b0;
          next_state_s = mem_ack_i ? S_REQ : S_DRAIN;
        end else if (id_stall_i && inst_valid_o) begin
          if (mem_ack_i) begin
            skid_load_s  = 1'b1;
            next_state_s = S_HOLD;
          end else begin
            next_state_s = S_REQ;
          end
        end else if (mem_ack_i) begin
          capture_s = 1'b1;
          stall_s   = 1'b0;
        end else begin
          bubble_s = 1'b1;
        end
      end
      S_DRAIN: begin
        // The stale request must stay on the bus until memory acks it.
        req_s = 1'b1;
        if (flush_i) begin
          clear_s = 1'b1;
          stall_s = 1'b0;
        end else if (mem_ack_i) begin
          next_state_s = S_REQ;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          clear_s      = 1'b1;
          stall_s      = 1'b0;
          next_state_s = S_REQ;
        end else if (!id_stall_i) begin
          // The held word moves into IF/ID, so the PC may now step past it.
          skid_pop_s   = 1'b1;
          stall_s      = 1'b0;
          next_state_s = S_REQ;
        end else begin
          next_state_s = S_HOLD;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  assign stall_o    = stall_s;
  assign mem_req_o  = req_s;
  assign mem_addr_o = addr_s;

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (clear_s),
    .capture    (capture_s),
    .skid_load  (skid_load_s),
    .skid_pop   (skid_pop_s),
    .bubble     (bubble_s),
    .word       (mem_rdata_i),
    .pc         (pc_i),
    .inst       (inst_o),
    .inst_pc    (inst_pc_o),
    .inst_valid (inst_valid_o)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench: PC register, memory and decode models drive the fetch unit;
// a scoreboard holds the program-order stream decode should receive.
module tb_inst_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        id_stall_i;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  always #5 clk_i = ~clk_i;

  inst_fetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] next_push;
  logic [31:0] tgt;
  int unsigned mem_wait;
  int unsigned max_wait;
  int unsigned p_stall;
  int unsigned p_flush;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        stall_s, req_s, ack_s, flush_s;
  logic [31:0] addr_s;
  logic        prev_flush = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = next_push;
      e.word = word_at(next_push);
      exp_q.push_back(e);
      next_push = next_push + 32'd1;
    end
  endtask

  task automatic restart_model();
    exp_q.delete();
    next_push = 32'd0;
    pc_i      = 32'd0;
    mem_wait  = 0;
    pend_v    = 1'b0;
    refill();
  endtask

  // One clock of PC register, memory and decode behaviour.
  task automatic cycle();
    @(negedge clk_i);
    id_stall_i = ($urandom_range(99) < p_stall);
    flush_i    = ($urandom_range(99) < p_flush);
    if (flush_i) begin
      tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : $urandom_range(4095);
      exp_q.delete();
      next_push = tgt;
    end
    if (mem_req_o && mem_wait == 0) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = word_at(mem_addr_o);
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
    end
    refill();
    #3;
    stall_s = stall_o;
    req_s   = mem_req_o;
    ack_s   = mem_ack_i;
    addr_s  = mem_addr_o;
    flush_s = flush_i;
    if (pend_v) begin
      check("req_held", 64'(req_s), 64'd1);
      check("addr_held", 64'(addr_s), 64'(pend_addr));
    end
    pend_v    = req_s && !ack_s;
    pend_addr = addr_s;
    @(posedge clk_i);
    #1;
    if (flush_s) pc_i = tgt;
    else if (!stall_s) pc_i = pc_i + 32'd1;
    if (req_s && ack_s) mem_wait = $urandom_range(max_wait);
    else if (req_s && mem_wait > 0) mem_wait = mem_wait - 1;
  endtask

  task automatic run_phase(input int unsigned w, input int unsigned ps, input int unsigned pf,
                           input int n);
    max_wait = w;
    p_stall  = ps;
    p_flush  = pf;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // First word reaches IF/ID on the second edge after reset with zero-wait memory.
  task automatic post_reset_checks();
    max_wait = 0;
    p_stall  = 0;
    p_flush  = 0;
    cycle();
    check("valid_cycle1", 64'(inst_valid_o), 64'd0);
    cycle();
    check("valid_cycle2", 64'(inst_valid_o), 64'd1);
    check("pc_cycle2", 64'(inst_pc_o), 64'd0);
    check("word_cycle2", 64'(inst_o), 64'(word_at(32'd0)));
    check("stall_after_idle", 64'(stall_s), 64'd0);
  endtask

  // Monitor: decode takes IF/ID on an edge with valid, no stall and no flush.
  always @(negedge clk_i) begin
    #3;
    if (!rst_i) begin
      if (prev_flush) begin
        check("flush_valid", 64'(inst_valid_o), 64'd0);
        check("flush_nop", 64'(inst_o), 64'd0);
      end
      if (inst_valid_o && !id_stall_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: actual pc %0h required none", inst_pc_o);
        end else begin
          e_mon = exp_q.pop_front();
          check("inst_pc", 64'(inst_pc_o), 64'(e_mon.pc));
          check("inst_word", 64'(inst_o), 64'(e_mon.word));
        end
      end
      prev_flush = flush_i;
    end else begin
      prev_flush = 1'b0;
    end
  end

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    id_stall_i  = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'd0;
    restart_model();
    #2;
    check("rst_stall", 64'(stall_o), 64'd1);
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    check("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    restart_model();
    post_reset_checks();

    run_phase(0, 0, 0, 40);
    run_phase(3, 0, 0, 150);
    run_phase(0, 35, 0, 150);
    run_phase(3, 35, 0, 200);
    run_phase(2, 30, 8, 300);
    run_phase(0, 0, 0, 10);

    // Asynchronous reset between edges while a request is on the bus.
    @(negedge clk_i);
    flush_i     = 1'b0;
    id_stall_i  = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = word_at(mem_addr_o);
    #1;
    check("pre_rst_req", 64'(mem_req_o), 64'd1);
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_req", 64'(mem_req_o), 64'd0);
    check("mid_rst_valid", 64'(inst_valid_o), 64'd0);
    check("mid_rst_stall", 64'(stall_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    mem_ack_i = 1'b0;
    restart_model();
    post_reset_checks();

    run_phase(3, 40, 12, 400);
    run_phase(1, 20, 5, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
